// File: rtl/sprite_plotter_pkg.sv
// sprite_plotter_pkg: screen geometry, colour type and FSM states shared by the sprite plotter.
package sprite_plotter_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    typedef logic [2:0] colour_t;
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: combinational sprite pattern ROM, built only with SPRITE_PLOTTER_ROM_EN.
module sprite_rom
    import sprite_plotter_pkg::*;
(
    input  logic [7:0] addr_i,
    output colour_t    data_o
);
    // Every seventh entry is 0, i.e. transparent.
    assign data_o = colour_t'(addr_i % 8'd7);
endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter: raster-scans a SPRITE_W x SPRITE_H sprite into the VGA adapter, clipping off-screen pixels.
// Define SPRITE_PLOTTER_ROM_EN to take per-pixel colours (0 = transparent) from sprite_rom instead of fg_colour.
module sprite_plotter
    import sprite_plotter_pkg::*;
#(
    parameter int      SPRITE_W  = 8,
    parameter int      SPRITE_H  = 8,
    parameter colour_t BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    input  logic       erase,
    input  logic [2:0] fg_colour,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);
    state_t     state_q, state_d;
    logic [3:0] col_q, col_d, row_q, row_d;
    logic [7:0] ox_q, ox_d;
    logic [6:0] oy_q, oy_d;
    logic       erase_q, erase_d;
    colour_t    fg_q, fg_d;
    logic [8:0] sx;
    logic [7:0] sy;
    logic       col_wrap, last, opaque, plot_d;
    colour_t    sprite_c, colour_d;

    assign col_wrap = col_q == 4'(SPRITE_W - 1);
    assign last     = col_wrap && row_q == 4'(SPRITE_H - 1);
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        erase_d = erase_q;
        fg_d    = fg_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = DRAW;
                col_d   = '0;
                row_d   = '0;
                ox_d    = org_x;
                oy_d    = org_y;
                erase_d = erase;
                fg_d    = fg_colour;
            end
            DRAW: if (last) state_d = DONE;
                  else begin
                      col_d = col_wrap ? 4'd0 : col_q + 4'd1;
                      row_d = col_wrap ? row_q + 4'd1 : row_q;
                  end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next pixel so they register in step with the scan.
    assign sx = {1'b0, ox_d} + {5'b0, col_d};
    assign sy = {1'b0, oy_d} + {4'b0, row_d};

`ifdef SPRITE_PLOTTER_ROM_EN
    logic [7:0] rom_addr;
    assign rom_addr = 8'(row_d) * 8'(SPRITE_W) + 8'(col_d);
    sprite_rom u_rom (.addr_i(rom_addr), .data_o(sprite_c));
    assign opaque = sprite_c != '0;
`else
    assign sprite_c = fg_d;
    assign opaque   = 1'b1;
`endif

    assign colour_d = erase_d ? BG_COLOUR : sprite_c;
    assign plot_d   = state_d == DRAW && sx < 9'(SCREEN_W) && sy < 8'(SCREEN_H) && (erase_d || opaque);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            erase_q    <= 1'b0;
            fg_q       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            erase_q    <= erase_d;
            fg_q       <= fg_d;
            vga_x      <= sx[7:0];
            vga_y      <= sy[6:0];
            vga_colour <= colour_d;
            vga_plot   <= plot_d;
        end
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: table-driven and randomized checks of sprite_plotter against a pixel-level reference model.
module tb_sprite_plotter;
    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, erase = 1'b0;
    logic [7:0] org_x = '0;
    logic [6:0] org_y = '0;
    logic [2:0] fg_colour = '0;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic [20:0] obs;
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [7:0] ox;
        logic [6:0] oy;
        logic       er;
        logic [2:0] fg;
        int         plots;
    } vec_t;
    vec_t tbl[$];

    sprite_plotter dut (
        .clk(clk), .reset(reset), .start(start), .org_x(org_x), .org_y(org_y),
        .erase(erase), .fg_colour(fg_colour), .busy(busy), .done(done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;
    assign obs = {busy, done, vga_plot, vga_x, vga_y, vga_colour};

    task automatic chk(input string nm, input logic [20:0] act, input logic [20:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Expected {busy,done,plot,x,y,colour} while the k-th pixel of the raster is presented.
    function automatic logic [20:0] model_pix(input logic [7:0] ox, input logic [6:0] oy,
                                              input logic er, input logic [2:0] fg, input int k);
        int x, y;
        logic [2:0] c;
        logic op;
        x = int'(ox) + k % W;
        y = int'(oy) + k / W;
`ifdef SPRITE_PLOTTER_ROM_EN
        c  = er ? 3'b000 : 3'(k % 7);
        op = er || (k % 7 != 0);
`else
        c  = er ? 3'b000 : fg;
        op = 1'b1;
`endif
        return {1'b1, 1'b0, (x < 160 && y < 120 && op), 8'(x), 7'(y), c};
    endfunction

    function automatic int model_count(input logic [7:0] ox, input logic [6:0] oy,
                                       input logic er, input logic [2:0] fg);
        int n = 0;
        for (int k = 0; k < N; k++) n += int'(model_pix(ox, oy, er, fg, k)[18]);
        return n;
    endfunction

    // Called at a negedge; start is sampled on the next rising edge.
    task automatic run_op(input logic [7:0] ox, input logic [6:0] oy, input logic er,
                          input logic [2:0] fg, input bit poke, input int abort_at, output int plots);
        plots = 0;
        start = 1'b1; org_x = ox; org_y = oy; erase = er; fg_colour = fg;
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge clk);
            start = poke && (c == 5 || c == N + 1);
            org_x = 8'($urandom); org_y = 7'($urandom); erase = 1'($urandom); fg_colour = 3'($urandom);
            if (c <= N) begin
                chk($sformatf("pix%0d_org%0d_%0d", c - 1, ox, oy), obs, model_pix(ox, oy, er, fg, c - 1));
                plots += int'(vga_plot);
            end else chk("done_pulse", {obs[20:18], 18'b0}, {3'b110, 18'b0});
            if (c == abort_at) begin
                #2 reset = 1'b1;
                #1 chk("async_reset", obs, '0);
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_after", {obs[20:18], 18'b0}, '0);
    endtask

    initial begin
        int p;
`ifdef SPRITE_PLOTTER_ROM_EN
        tbl.push_back('{8'd10,  7'd20,  1'b0, 3'd4, 54});
        tbl.push_back('{8'd10,  7'd20,  1'b1, 3'd4, 64});
        tbl.push_back('{8'd200, 7'd0,   1'b0, 3'd1, 0});
`else
        tbl.push_back('{8'd10,  7'd20,  1'b0, 3'd4, 64});
        tbl.push_back('{8'd156, 7'd20,  1'b0, 3'd2, 32});
        tbl.push_back('{8'd0,   7'd116, 1'b1, 3'd5, 32});
        tbl.push_back('{8'd152, 7'd112, 1'b0, 3'd7, 64});
        tbl.push_back('{8'd200, 7'd50,  1'b0, 3'd1, 0});
        tbl.push_back('{8'd159, 7'd119, 1'b0, 3'd0, 1});
        tbl.push_back('{8'd255, 7'd127, 1'b1, 3'd3, 0});
`endif
        repeat (2) @(negedge clk);
        chk("reset_state", obs, '0);
        reset = 1'b0;
        foreach (tbl[i]) begin
            run_op(tbl[i].ox, tbl[i].oy, tbl[i].er, tbl[i].fg, 1'b0, 0, p);
            chk($sformatf("plots_vec%0d", i), 21'(p), 21'(tbl[i].plots));
        end
        run_op(8'd10, 7'd20, 1'b0, 3'd4, 1'b1, 0, p);
        chk("plots_restart_ignored", 21'(p), 21'(model_count(8'd10, 7'd20, 1'b0, 3'd4)));
        run_op(8'd40, 7'd60, 1'b0, 3'd3, 1'b0, 0, p);
        chk("plots_after_restart", 21'(p), 21'(model_count(8'd40, 7'd60, 1'b0, 3'd3)));
        run_op(8'd20, 7'd30, 1'b0, 3'd6, 1'b0, 30, p);
        repeat (2) begin
            @(negedge clk);
            chk("reset_hold", obs, '0);
        end
        reset = 1'b0;
        run_op(8'd20, 7'd30, 1'b0, 3'd6, 1'b0, 0, p);
        chk("plots_after_abort", 21'(p), 21'(model_count(8'd20, 7'd30, 1'b0, 3'd6)));
        repeat (20) begin
            logic [7:0] ox;
            logic [6:0] oy;
            logic er;
            logic [2:0] fg;
            bit pk;
            ox = 8'($urandom); oy = 7'($urandom); er = 1'($urandom); fg = 3'($urandom); pk = 1'($urandom);
            run_op(ox, oy, er, fg, pk, 0, p);
            chk("plots_random", 21'(p), 21'(model_count(ox, oy, er, fg)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sprite_plotter.md
SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 Parameter: SPRITE_W, default 8, sprite width in pixels (1..16).
REQ-002 Parameter: SPRITE_H, default 8, sprite height in pixels (1..16).
REQ-003 Parameter: BG_COLOUR, default 3'b000, colour written when erasing.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: start  in  1  request to draw or erase one sprite at the latched origin.
REQ-007 Port: org_x  in  8  sprite top-left x.
REQ-008 Port: org_y  in  7  sprite top-left y.
REQ-009 Port: erase  in  1  1 = paint BG_COLOUR; 0 = paint the sprite.
REQ-010 Port: fg_colour  in  3  solid sprite colour (used only without the ROM).
REQ-011 Port: busy  out  1  high whenever the state is not IDLE.
REQ-012 Port: done  out  1  one-cycle pulse at the end of the operation.
REQ-013 Port: vga_x  out  8  pixel x to the VGA adapter.
REQ-014 Port: vga_y  out  7  pixel y to the VGA adapter.
REQ-015 Port: vga_colour  out  3  pixel colour to the VGA adapter.
REQ-016 Port: vga_plot  out  1  write strobe to the VGA adapter.

Function
REQ-017 The FSM SHALL have states IDLE, DRAW and DONE: IDLE->DRAW on start; DRAW->DONE after the last pixel; DONE->IDLE unconditionally.
REQ-018 start SHALL be accepted only in IDLE; start in DRAW or DONE is ignored, with no queueing.
REQ-019 On acceptance, org_x, org_y, erase and fg_colour SHALL be latched; later input changes have no effect until the next acceptance.
REQ-020 DRAW SHALL scan exactly SPRITE_W*SPRITE_H pixels in raster order, column fastest, one pixel per cycle, no stalls.
REQ-021 All vga_* outputs SHALL be registered; pixel (0,0) is presented in the cycle after start is sampled.
REQ-022 vga_x SHALL equal latched org_x + col, and vga_y SHALL equal latched org_y + row; sums are formed at 9 and 8 bits, then truncated.
REQ-023 Clipping: vga_plot SHALL be 0 for any pixel whose untruncated x >= 160 or y >= 120; the scan still consumes that cycle.
REQ-024 vga_colour SHALL be BG_COLOUR when latched erase = 1; otherwise it is the sprite colour (REQ-031/032).
REQ-025 done SHALL be high for exactly the single DONE cycle; vga_plot SHALL be 0 in DONE and IDLE.
REQ-026 Total latency from start sample to the done pulse SHALL be SPRITE_W*SPRITE_H+1 cycles; busy stays high throughout.
REQ-027 start asserted in the DONE cycle SHALL be ignored; the earliest next acceptance is the following IDLE cycle.

Reset
REQ-028 reset SHALL asynchronously force the IDLE state, clear both counters, and drive busy, done, vga_plot, vga_x, vga_y and vga_colour to 0.
REQ-029 A reset during DRAW SHALL abort the scan with no done pulse, and no further vga_plot occurs until a new start.
REQ-030 After reset deasserts, the first clock edge SHALL accept a start.

Configuration
REQ-031 With SPRITE_PLOTTER_ROM_EN defined: the sprite colour SHALL come from a SPRITE_W*SPRITE_H x 3-bit pattern ROM indexed by row*SPRITE_W+col; ROM entry 3'b000 means transparent, which forces vga_plot = 0 when not erasing; fg_colour is unused.
REQ-032 Without the macro: the sprite colour SHALL be fg_colour for every pixel, no ROM is instantiated, and there is no transparency.

Structure
REQ-033 A shared package SHALL hold SCREEN_W = 160, SCREEN_H = 120, the 3-bit colour type and the state enum.
REQ-034 The pattern ROM SHALL be a separate sub-module, sprite_rom, with a combinational read; the ROM address SHALL be aligned with the registered outputs.

Verification
REQ-035 Scenario: org (10,20), erase 0, fg_colour 3'b100, no ROM -> 64 plots covering x 10..17 and y 20..27 in raster order, all colour 4, done at cycle 65.
REQ-036 Scenario: org (156,20) -> only x 156..159 plot, giving 32 plots; x 160..163 cycles have vga_plot 0; done is still at cycle 65.
REQ-037 Scenario: org (0,116), erase 1 -> 32 plots with y 116..119 and colour 3'b000.
REQ-038 Scenario: start re-pulsed at cycles 5 and 65 -> both ignored; exactly one done pulse; the next start in IDLE is accepted.
REQ-039 Scenario: reset asserted at DRAW pixel 30 -> all outputs are 0 asynchronously; no done pulse; the next start produces a full 64-pixel scan.
REQ-040 Scenario (ROM): a pattern with 10 zero entries and erase 0 -> 54 plots matching the ROM; with erase 1 -> 64 plots of BG_COLOUR.
